// File: rtl/bcd_entry.sv
// bcd_entry: accumulates BCD digits (most significant first) into an
// unsigned binary value, commits it on enter with a one-cycle strobe, and
// latches an error on invalid BCD or on overflow until clear or rst.
module bcd_entry #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       digit,
    input  logic             digit_valid,
    output logic             digit_ready,
    input  logic             enter,
    input  logic             clear,
    output logic [WIDTH-1:0] acc,
    output logic [1:0]       ndigits,
    output logic [WIDTH-1:0] num,
    output logic             num_valid,
    output logic             err
);

    localparam int unsigned XW = WIDTH + 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [1:0]       ndigits_q, ndigits_d;
    logic             num_valid_q, num_valid_d;
    logic             err_q, err_d;

    logic             accept;
    logic             bad_digit;
    logic             overflow;
    logic [XW-1:0]    next_val;

    // Ready depends on registered state only, so it never loops back through digit_valid.
    assign digit_ready = (state_q == S_IDLE) ||
                         ((state_q == S_ACCUM) && (ndigits_q < 2'(DIGITS)));
    assign accept      = digit_valid && digit_ready;
    assign bad_digit   = digit > 4'd9;
    assign next_val    = XW'(acc_q) * XW'(10) + XW'(digit);
    assign overflow    = next_val > XW'({WIDTH{1'b1}});

    // Next-state and datapath: clear wins, then digit accept, then a plain enter.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        num_d       = num_q;
        ndigits_d   = ndigits_q;
        num_valid_d = 1'b0;
        err_d       = err_q;

        if (clear) begin
            state_d   = S_IDLE;
            acc_d     = '0;
            ndigits_d = 2'd0;
            err_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        if (bad_digit || overflow) begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                        end else if (enter) begin
                            // Commit includes the digit arriving alongside enter.
                            num_d       = next_val[WIDTH-1:0];
                            num_valid_d = 1'b1;
                            acc_d       = '0;
                            ndigits_d   = 2'd0;
                            state_d     = S_IDLE;
                        end else begin
                            acc_d     = next_val[WIDTH-1:0];
                            ndigits_d = ndigits_q + 2'd1;
                            state_d   = S_ACCUM;
                        end
                    end else if (enter && (state_q == S_ACCUM)) begin
                        num_d       = acc_q;
                        num_valid_d = 1'b1;
                        acc_d       = '0;
                        ndigits_d   = 2'd0;
                        state_d     = S_IDLE;
                    end
                end
                S_ERROR: begin
                    // Frozen until clear or rst.
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            num_q       <= '0;
            ndigits_q   <= 2'd0;
            num_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            num_q       <= num_d;
            ndigits_q   <= ndigits_d;
            num_valid_q <= num_valid_d;
            err_q       <= err_d;
        end
    end

    assign acc       = acc_q;
    assign ndigits   = ndigits_q;
    assign num       = num_q;
    assign num_valid = num_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_entry.sv
// Bench for bcd_entry: two instances (DIGITS=2 and DIGITS=3, WIDTH=8) share
// stimulus and are checked against an arithmetic model of digit entry.
module tb_bcd_entry;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit;
    logic       digit_valid, enter, clear;

    logic       rdy0, rdy1, nv0, nv1, err0, err1;
    logic [7:0] acc0, acc1, num0, num1;
    logic [1:0] nd0, nd1;

    int tests = 0;
    int fails = 0;

    // Model state per instance: value typed so far, digit count, committed value, strobe, error.
    int m_dig[2]  = '{2, 3};
    int m_acc[2];
    int m_n[2];
    int m_num[2];
    int m_nv[2];
    int m_err[2];

    always #5 clk = ~clk;

    bcd_entry #(.DIGITS(2), .WIDTH(8)) u_d2 (
        .clk(clk), .rst(rst), .digit(digit), .digit_valid(digit_valid),
        .digit_ready(rdy0), .enter(enter), .clear(clear), .acc(acc0),
        .ndigits(nd0), .num(num0), .num_valid(nv0), .err(err0)
    );

    bcd_entry #(.DIGITS(3), .WIDTH(8)) u_d3 (
        .clk(clk), .rst(rst), .digit(digit), .digit_valid(digit_valid),
        .digit_ready(rdy1), .enter(enter), .clear(clear), .acc(acc1),
        .ndigits(nd1), .num(num1), .num_valid(nv1), .err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_ready(input int i);
        return (m_err[i] == 0 && m_n[i] < m_dig[i]) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0; m_n[i] = 0; m_num[i] = 0; m_nv[i] = 0; m_err[i] = 0;
        end
    endtask

    // One clock of the entry rules applied to both models.
    task automatic model_step(input int dv, input int d, input int en, input int cl);
        for (int i = 0; i < 2; i++) begin
            int nxt;
            int rdy;
            rdy = m_ready(i);
            nxt = m_acc[i] * 10 + d;
            m_nv[i] = 0;
            if (cl != 0) begin
                m_acc[i] = 0; m_n[i] = 0; m_err[i] = 0;
            end else if (dv != 0 && rdy != 0) begin
                if (d > 9 || nxt > 255) begin
                    m_err[i] = 1;
                end else if (en != 0) begin
                    m_num[i] = nxt; m_nv[i] = 1; m_acc[i] = 0; m_n[i] = 0;
                end else begin
                    m_acc[i] = nxt; m_n[i] = m_n[i] + 1;
                end
            end else if (en != 0 && m_err[i] == 0 && m_n[i] > 0) begin
                m_num[i] = m_acc[i]; m_nv[i] = 1; m_acc[i] = 0; m_n[i] = 0;
            end
        end
    endtask

    task automatic check_outs();
        chk("d2_acc", 32'(acc0), 32'(m_acc[0]));
        chk("d2_ndigits", 32'(nd0), 32'(m_n[0]));
        chk("d2_num", 32'(num0), 32'(m_num[0]));
        chk("d2_num_valid", 32'(nv0), 32'(m_nv[0]));
        chk("d2_err", 32'(err0), 32'(m_err[0]));
        chk("d3_acc", 32'(acc1), 32'(m_acc[1]));
        chk("d3_ndigits", 32'(nd1), 32'(m_n[1]));
        chk("d3_num", 32'(num1), 32'(m_num[1]));
        chk("d3_num_valid", 32'(nv1), 32'(m_nv[1]));
        chk("d3_err", 32'(err1), 32'(m_err[1]));
    endtask

    // Called #1 after a rising edge: drive, check ready, advance one edge, check outputs.
    task automatic cycle(input int dv, input int d, input int en, input int cl);
        digit_valid = 1'(dv);
        digit       = 4'(d);
        enter       = 1'(en);
        clear       = 1'(cl);
        #1;
        chk("d2_digit_ready", 32'(rdy0), 32'(m_ready(0)));
        chk("d3_digit_ready", 32'(rdy1), 32'(m_ready(1)));
        model_step(dv, d, en, cl);
        @(posedge clk);
        #1;
        check_outs();
    endtask

    initial begin
        rst = 1'b1; digit = 4'd0; digit_valid = 1'b0; enter = 1'b0; clear = 1'b0;
        model_reset();
        #12;
        check_outs();
        chk("reset_ready_d2", 32'(rdy0), 32'd1);
        chk("reset_ready_d3", 32'(rdy1), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 4, 7, enter -> 47
        cycle(1, 4, 0, 0);
        chk("plan_acc4", 32'(acc0), 32'd4);
        cycle(1, 7, 0, 0);
        chk("plan_acc47", 32'(acc0), 32'd47);
        cycle(0, 0, 1, 0);
        chk("plan_num47", 32'(num0), 32'd47);
        chk("plan_strobe47", 32'(nv0), 32'd1);
        cycle(0, 0, 1, 0);
        chk("plan_no_second_strobe", 32'(nv0), 32'd0);

        // 9, 9, 5 back to back: third digit refused by the 2-digit entry
        cycle(1, 9, 0, 0);
        cycle(1, 9, 0, 0);
        cycle(1, 5, 0, 0);
        chk("plan_refused_acc", 32'(acc0), 32'd99);
        chk("plan_refused_err", 32'(err0), 32'd0);
        cycle(0, 0, 1, 0);
        chk("plan_num99", 32'(num0), 32'd99);
        cycle(1, 0, 0, 1);

        // invalid BCD digit, enter ignored in error, clear recovers
        cycle(1, 11, 0, 0);
        chk("plan_err_set", 32'(err0), 32'd1);
        cycle(0, 0, 1, 0);
        chk("plan_err_no_strobe", 32'(nv0), 32'd0);
        chk("plan_err_num_kept", 32'(num0), 32'd99);
        cycle(0, 0, 0, 1);
        chk("plan_err_cleared", 32'(err0), 32'd0);

        // 3-digit entry: 255 commits, 256 overflows and keeps 25
        cycle(1, 2, 0, 0);
        cycle(1, 5, 0, 0);
        cycle(1, 5, 0, 0);
        cycle(0, 0, 1, 0);
        chk("plan_num255", 32'(num1), 32'd255);
        cycle(1, 2, 0, 0);
        cycle(1, 5, 0, 0);
        cycle(1, 6, 0, 0);
        chk("plan_ovf_err", 32'(err1), 32'd1);
        chk("plan_ovf_acc25", 32'(acc1), 32'd25);
        cycle(0, 0, 0, 1);

        // enter with a digit in the same cycle, then clear beating enter
        cycle(1, 3, 0, 0);
        cycle(1, 8, 1, 0);
        chk("plan_num38", 32'(num0), 32'd38);
        cycle(1, 4, 0, 0);
        cycle(0, 0, 1, 1);
        chk("plan_clear_no_strobe", 32'(nv0), 32'd0);
        chk("plan_clear_acc0", 32'(acc0), 32'd0);

        // asynchronous reset between edges
        cycle(1, 6, 0, 0);
        digit_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outs();
        chk("async_ready_d2", 32'(rdy0), 32'd1);
        chk("async_ready_d3", 32'(rdy1), 32'd1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            int dv, d, en, cl;
            dv = ($urandom_range(0, 3) != 0) ? 1 : 0;
            d  = ($urandom_range(0, 15) < 13) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 15));
            en = ($urandom_range(0, 4) == 0) ? 1 : 0;
            cl = ($urandom_range(0, 11) == 0) ? 1 : 0;
            cycle(dv, d, en, cl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
